latch_bank_sequencer: RTL



---
 rtl/latch_bank_sequencer.sv | 89 ++++++++
 1 files changed

// File: rtl/latch_bank_sequencer.sv
// latch_bank_sequencer: round-robin write sequencer for a shared-bus D-latch register bank (optional LATCH_READBACK_EN adds a post-write verify)
module latch_bank_sequencer #(
   parameter int NREQ = 2,
   parameter int WIDTH = 8,
   parameter int NREG = 4,
   parameter int EN_CYCLES = 1,
   localparam int AW = NREG > 1 ? $clog2(NREG) : 1,
   localparam int GW = $clog2(NREQ)
) (
   input logic clk,
   input logic rst_n,
   input logic [NREQ-1:0] req,
   input logic [NREQ*AW-1:0] req_addr,
   input logic [NREQ*WIDTH-1:0] req_data,
`ifdef LATCH_READBACK_EN
   input logic [WIDTH-1:0] latch_q,
   output logic wr_err,
`endif
   output logic [NREQ-1:0] ack,
   output logic busy,
   output logic [GW-1:0] grant_id,
   output logic [WIDTH-1:0] latch_d,
   output logic [NREG-1:0] latch_c
);
`ifdef LATCH_READBACK_EN
   typedef enum logic [2:0] {IDLE, SETUP, ENABLE, HOLD, VERIFY, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, SETUP, ENABLE, HOLD, DONE} state_t;
`endif
   state_t state, nxt;
   logic [GW-1:0] ptr, gnt, j;
   logic [AW-1:0] addr_q;
   logic [3:0] cnt;
   assign busy = state != IDLE;
   // pick the first requester at or after the pointer and decode the next state
   always_comb begin
      gnt = ptr;
      j = ptr;
      for (int i = NREQ - 1; i >= 0; i--) begin
         j = GW'((int'(ptr) + i) % NREQ);
         if (req[j]) gnt = j;
      end
      nxt = state;
      case (state)
         IDLE: nxt = |req ? SETUP : IDLE;
         SETUP: nxt = ENABLE;
         ENABLE: nxt = cnt == 4'd0 ? HOLD : ENABLE;
`ifdef LATCH_READBACK_EN
         HOLD: nxt = VERIFY;
         VERIFY: nxt = DONE;
`else
         HOLD: nxt = DONE;
`endif
         default: nxt = IDLE;
      endcase
   end
   // state, pointer, captured transaction and registered latch/ack outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr <= '0;
         grant_id <= '0;
         addr_q <= '0;
         cnt <= 4'd0;
         latch_d <= '0;
         latch_c <= '0;
         ack <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && |req) begin
            grant_id <= gnt;
            addr_q <= req_addr[gnt*AW +: AW];
            latch_d <= req_data[gnt*WIDTH +: WIDTH];
         end
         if (state == SETUP) cnt <= 4'(EN_CYCLES - 1);
         else if (state == ENABLE && cnt != 4'd0) cnt <= cnt - 4'd1;
         latch_c <= (nxt == ENABLE && int'(addr_q) < NREG) ? NREG'(1) << addr_q : '0;
         ack <= nxt == DONE ? NREQ'(1) << grant_id : '0;
         if (state == DONE) ptr <= grant_id == GW'(NREQ - 1) ? '0 : grant_id + 1'b1;
      end
   end
`ifdef LATCH_READBACK_EN
   // flag a readback mismatch so it lands in the same cycle as the ack
   always_ff @(posedge clk) begin
      if (!rst_n) wr_err <= 1'b0;
      else wr_err <= state == VERIFY && latch_q != latch_d;
   end
`endif
endmodule
